// File: rtl/tlc_pkg.sv
// Shared types and defaults for the traffic-light demand detector.
// Vehicle counting is enabled by TLC_VEHICLE_COUNT_EN.
package tlc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUAL    = 2'd1,
    LATCHED = 2'd2
  } sensor_state_t;

  localparam int DEBOUNCE_CYCLES_DEF = 8;
  localparam int CNT_W_DEF           = 8;

  function automatic bit cfg_ok(int db, int cw);
    return (db >= 2) && (db <= 255) && (cw >= 1);
  endfunction

endpackage

// File: rtl/tlc_demand_detector_if.sv
// Sensor/served inputs and demand outputs of the demand detector.
// Count signals exist only with TLC_VEHICLE_COUNT_EN.
interface tlc_demand_detector_if #(
  parameter int CNT_W = tlc_pkg::CNT_W_DEF
) ();

  logic main_sensor_raw;
  logic side_sensor_raw;
  logic main_served;
  logic side_served;
  logic main_road_traffic;
  logic side_road_traffic;
`ifdef TLC_VEHICLE_COUNT_EN
  logic [CNT_W-1:0] main_vehicle_count;
  logic [CNT_W-1:0] side_vehicle_count;
`endif

  modport master (
    output main_sensor_raw,
    output side_sensor_raw,
    output main_served,
    output side_served,
    input  main_road_traffic,
    input  side_road_traffic
`ifdef TLC_VEHICLE_COUNT_EN
    ,
    input  main_vehicle_count,
    input  side_vehicle_count
`endif
  );

  modport slave (
    input  main_sensor_raw,
    input  side_sensor_raw,
    input  main_served,
    input  side_served,
    output main_road_traffic,
    output side_road_traffic
`ifdef TLC_VEHICLE_COUNT_EN
    ,
    output main_vehicle_count,
    output side_vehicle_count
`endif
  );

endinterface

// File: rtl/tlc_sensor_channel.sv
// One sensor lane: synchronizer, debounce FSM, optional vehicle counter.
// Vehicle counter present only with TLC_VEHICLE_COUNT_EN.
module tlc_sensor_channel
  import tlc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sensor_raw,
  input  logic             served,
`ifdef TLC_VEHICLE_COUNT_EN
  output logic [CNT_W-1:0] vehicle_count,
`endif
  output logic             demand
);

  localparam int QW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [QW-1:0] DB = QW'(DEBOUNCE_CYCLES);

  if (!cfg_ok(DEBOUNCE_CYCLES, CNT_W)) begin : g_cfg_err
    $error("tlc_sensor_channel: bad parameters");
  end

  logic [1:0]    sync_q;
  logic          sync;
  sensor_state_t state_q, state_d;
  logic [QW-1:0] qcnt_q, qcnt_d;
`ifdef TLC_VEHICLE_COUNT_EN
  logic [CNT_W-1:0] vcnt_q, vcnt_d;
`endif

  assign sync   = sync_q[1];
  assign demand = (state_q == LATCHED);

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q  <= '0;
      state_q <= IDLE;
      qcnt_q  <= '0;
`ifdef TLC_VEHICLE_COUNT_EN
      vcnt_q  <= '0;
`endif
    end else begin
      sync_q  <= {sync_q[0], sensor_raw};
      state_q <= state_d;
      qcnt_q  <= qcnt_d;
`ifdef TLC_VEHICLE_COUNT_EN
      vcnt_q  <= vcnt_d;
`endif
    end
  end

  // served is only honoured in LATCHED so a demand is never lost
  always_comb begin
    state_d = state_q;
    qcnt_d  = qcnt_q;
`ifdef TLC_VEHICLE_COUNT_EN
    vcnt_d  = vcnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (sync) begin
          state_d = QUAL;
          qcnt_d  = QW'(1);
        end
      end
      QUAL: begin
        if (!sync) begin
          state_d = IDLE;
          qcnt_d  = '0;
        end else if (qcnt_q == DB) begin
          state_d = LATCHED;
          qcnt_d  = '0;
`ifdef TLC_VEHICLE_COUNT_EN
          if (vcnt_q != '1)
            vcnt_d = vcnt_q + 1'b1;
`endif
        end else begin
          qcnt_d = qcnt_q + 1'b1;
        end
      end
      LATCHED: begin
        if (served)
          state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        qcnt_d  = '0;
      end
    endcase
  end

`ifdef TLC_VEHICLE_COUNT_EN
  assign vehicle_count = vcnt_q;
`endif

endmodule

// File: rtl/tlc_demand_detector.sv
// Debounced main/side road demand for the traffic-light controller.
// Define TLC_VEHICLE_COUNT_EN to add per-road vehicle counters.
module tlc_demand_detector
  import tlc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input logic                 clk,
  input logic                 rst,
  tlc_demand_detector_if.slave bus
);

  if (!cfg_ok(DEBOUNCE_CYCLES, CNT_W)) begin : g_cfg_err
    $error("tlc_demand_detector: bad parameters");
  end

  tlc_sensor_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_main (
    .clk           (clk),
    .rst           (rst),
    .sensor_raw    (bus.main_sensor_raw),
    .served        (bus.main_served),
`ifdef TLC_VEHICLE_COUNT_EN
    .vehicle_count (bus.main_vehicle_count),
`endif
    .demand        (bus.main_road_traffic)
  );

  tlc_sensor_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_side (
    .clk           (clk),
    .rst           (rst),
    .sensor_raw    (bus.side_sensor_raw),
    .served        (bus.side_served),
`ifdef TLC_VEHICLE_COUNT_EN
    .vehicle_count (bus.side_vehicle_count),
`endif
    .demand        (bus.side_road_traffic)
  );

endmodule

// File: tb/tb_tlc_demand_detector.sv
// Directed bench for tlc_demand_detector (DEBOUNCE_CYCLES=4, CNT_W=3).
// Count checks run only when TLC_VEHICLE_COUNT_EN is defined.
module tb_tlc_demand_detector;

  localparam int DB = 4;
  localparam int CW = 3;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  tlc_demand_detector_if #(.CNT_W(CW)) bus ();

  tlc_demand_detector #(
    .DEBOUNCE_CYCLES (DB),
    .CNT_W           (CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    bus.main_sensor_raw = 1'b0;
    bus.side_sensor_raw = 1'b0;
    bus.main_served = 1'b0;
    bus.side_served = 1'b0;
    tick(2);
    total++;
    if (bus.main_road_traffic !== 1'b0) begin
      bad++;
      $display("FAIL rst_main got=%b exp=0", bus.main_road_traffic);
    end
    total++;
    if (bus.side_road_traffic !== 1'b0) begin
      bad++;
      $display("FAIL rst_side got=%b exp=0", bus.side_road_traffic);
    end
`ifdef TLC_VEHICLE_COUNT_EN
    total++;
    if (bus.main_vehicle_count !== 3'd0 ||
        bus.side_vehicle_count !== 3'd0) begin
      bad++;
      $display("FAIL rst_cnt got=%0d/%0d exp=0/0",
               bus.main_vehicle_count, bus.side_vehicle_count);
    end
`endif
    rst = 1'b1;
    tick(1);
  endtask

  // latency, hold, serve with sensor high, requalify, serve after release
  task automatic test_main_latch;
    logic e;
    bus.main_sensor_raw = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      e = (k >= DB + 3);
      total++;
      if (bus.main_road_traffic !== e) begin
        bad++;
        $display("FAIL latch_edge%0d got=%b exp=%b",
                 k, bus.main_road_traffic, e);
      end
    end
    bus.main_served = 1'b1;
    tick(1);
    bus.main_served = 1'b0;
    total++;
    if (bus.main_road_traffic !== 1'b0) begin
      bad++;
      $display("FAIL serve_clear got=%b exp=0", bus.main_road_traffic);
    end
    for (int k = 1; k <= 5; k++) begin
      tick(1);
      e = (k == 5);
      total++;
      if (bus.main_road_traffic !== e) begin
        bad++;
        $display("FAIL requal_edge%0d got=%b exp=%b",
                 k, bus.main_road_traffic, e);
      end
    end
    bus.main_sensor_raw = 1'b0;
    tick(4);
    total++;
    if (bus.main_road_traffic !== 1'b1) begin
      bad++;
      $display("FAIL hold_low got=%b exp=1", bus.main_road_traffic);
    end
    bus.main_served = 1'b1;
    tick(1);
    bus.main_served = 1'b0;
    tick(3);
    total++;
    if (bus.main_road_traffic !== 1'b0) begin
      bad++;
      $display("FAIL serve_idle got=%b exp=0", bus.main_road_traffic);
    end
  endtask

  task automatic test_side_glitch;
    logic [7:0] pat;
    pat = 8'b0111_0111;
    for (int k = 0; k < 14; k++) begin
      bus.side_sensor_raw = (k < 8) ? pat[7-k] : 1'b0;
      tick(1);
      total++;
      if (bus.side_road_traffic !== 1'b0) begin
        bad++;
        $display("FAIL glitch_edge%0d got=%b exp=0",
                 k, bus.side_road_traffic);
      end
    end
  endtask

  // served pulses during QUAL and on the QUAL->LATCHED edge are ignored
  task automatic test_served_on_latch_edge;
    logic e;
    bus.main_sensor_raw = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      bus.main_served = (k == 5) || (k == DB + 3);
      tick(1);
      bus.main_served = 1'b0;
      e = (k >= DB + 3);
      total++;
      if (bus.main_road_traffic !== e) begin
        bad++;
        $display("FAIL svc_latch_edge%0d got=%b exp=%b",
                 k, bus.main_road_traffic, e);
      end
    end
    bus.main_sensor_raw = 1'b0;
    tick(3);
    bus.main_served = 1'b1;
    tick(1);
    bus.main_served = 1'b0;
    tick(2);
  endtask

  task automatic test_reset_latched;
    bus.main_sensor_raw = 1'b1;
    bus.side_sensor_raw = 1'b1;
    tick(DB + 3);
    total++;
    if (bus.main_road_traffic !== 1'b1 ||
        bus.side_road_traffic !== 1'b1) begin
      bad++;
      $display("FAIL both_latch got=%b%b exp=11",
               bus.main_road_traffic, bus.side_road_traffic);
    end
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    total++;
    if (bus.main_road_traffic !== 1'b0 ||
        bus.side_road_traffic !== 1'b0) begin
      bad++;
      $display("FAIL rst_latched got=%b%b exp=00",
               bus.main_road_traffic, bus.side_road_traffic);
    end
`ifdef TLC_VEHICLE_COUNT_EN
    total++;
    if (bus.main_vehicle_count !== 3'd0 ||
        bus.side_vehicle_count !== 3'd0) begin
      bad++;
      $display("FAIL rst_latched_cnt got=%0d/%0d exp=0/0",
               bus.main_vehicle_count, bus.side_vehicle_count);
    end
`endif
    tick(DB + 2);
    total++;
    if (bus.main_road_traffic !== 1'b0) begin
      bad++;
      $display("FAIL requal_early got=%b exp=0", bus.main_road_traffic);
    end
    tick(1);
    total++;
    if (bus.main_road_traffic !== 1'b1 ||
        bus.side_road_traffic !== 1'b1) begin
      bad++;
      $display("FAIL requal_both got=%b%b exp=11",
               bus.main_road_traffic, bus.side_road_traffic);
    end
    bus.main_sensor_raw = 1'b0;
    bus.side_sensor_raw = 1'b0;
    tick(3);
    bus.main_served = 1'b1;
    bus.side_served = 1'b1;
    tick(1);
    bus.main_served = 1'b0;
    bus.side_served = 1'b0;
    tick(2);
    total++;
    if (bus.main_road_traffic !== 1'b0 ||
        bus.side_road_traffic !== 1'b0) begin
      bad++;
      $display("FAIL both_served got=%b%b exp=00",
               bus.main_road_traffic, bus.side_road_traffic);
    end
  endtask

  task automatic test_count_sat;
`ifdef TLC_VEHICLE_COUNT_EN
    int e;
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      bus.main_sensor_raw = 1'b1;
      tick(DB + 3);
      bus.main_sensor_raw = 1'b0;
      e = (i > 7) ? 7 : i;
      total++;
      if (bus.main_road_traffic !== 1'b1 ||
          bus.main_vehicle_count !== 3'(e)) begin
        bad++;
        $display("FAIL cnt_iter%0d got=%b/%0d exp=1/%0d", i,
                 bus.main_road_traffic, bus.main_vehicle_count, e);
      end
      tick(3);
      bus.main_served = 1'b1;
      tick(1);
      bus.main_served = 1'b0;
      tick(2);
    end
    total++;
    if (bus.side_vehicle_count !== 3'd0) begin
      bad++;
      $display("FAIL side_cnt got=%0d exp=0", bus.side_vehicle_count);
    end
`endif
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_main_latch();
    test_side_glitch();
    test_served_on_latch_edge();
    test_reset_latched();
    test_count_sat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
